// File: rtl/button_debouncer.sv
// ============================================================================
// Module   : button_debouncer
// Brief    : Two-flop synchroniser, per-button debounce and press/release/
//            long-press pulse generation. Optional HOLD_REPEAT_EN adds
//            auto-repeat press pulses while a button is held past long-press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int N_BTN         = 3,
    parameter int DB_CYCLES     = 2000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int REPEAT_CYCLES = 20000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] button_raw,
    input  logic             lock,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    localparam int c_DBC_W = $clog2(DB_CYCLES);
    localparam int c_HC_W  = $clog2(LONG_CYCLES + 1);

    localparam logic [c_DBC_W-1:0] c_DB_LAST   = c_DBC_W'(DB_CYCLES - 1);
    localparam logic [c_HC_W-1:0]  c_LONG_LAST = c_HC_W'(LONG_CYCLES - 1);
    localparam logic [c_HC_W-1:0]  c_LONG_MAX  = c_HC_W'(LONG_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    if (DB_CYCLES < 2 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("button_debouncer: invalid cycle parameters");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [c_DBC_W-1:0] r_dbc;
        logic               r_level;
        logic               w_differ;
        logic               w_accept;
        logic               w_rise;
        logic               w_fall;
        state_t             r_state;
        state_t             w_state_nxt;
        logic [c_HC_W-1:0]  r_hc;
        logic [c_HC_W-1:0]  w_hc_nxt;
        logic               w_long;
        logic               w_repeat;
        logic               r_press;
        logic               r_release;
        logic               r_long;

        // Any sample matching the current level restarts the stability count.
        assign w_differ = r_sync2[i] ^ r_level;
        assign w_accept = w_differ && (r_dbc == c_DB_LAST);
        assign w_rise   = w_accept &&  r_sync2[i];
        assign w_fall   = w_accept && !r_sync2[i];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_dbc   <= '0;
                r_level <= 1'b0;
            end else begin
                if (!w_differ || w_accept) begin
                    r_dbc <= '0;
                end else begin
                    r_dbc <= r_dbc + 1'b1;
                end
                if (w_accept) begin
                    r_level <= r_sync2[i];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_hc    <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_hc    <= w_hc_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_hc_nxt    = r_hc;
            w_long      = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HELD;
                        w_hc_nxt    = '0;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hc_nxt    = '0;
                    end else begin
                        if (r_hc == c_LONG_LAST) begin
                            w_long      = 1'b1;
                            w_state_nxt = ST_LONG;
                        end
                        if (r_hc != c_LONG_MAX) begin
                            w_hc_nxt = r_hc + 1'b1;
                        end
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                        w_hc_nxt    = '0;
                    end else if (r_hc != c_LONG_MAX) begin
                        w_hc_nxt = r_hc + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_hc_nxt    = '0;
                end
            endcase
        end

`ifdef HOLD_REPEAT_EN
        localparam int c_RC_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        localparam logic [c_RC_W-1:0] c_REP_LAST = c_RC_W'(REPEAT_CYCLES - 1);

        logic [c_RC_W-1:0] r_rc;

        // Repeat phase restarts from zero every time LONG is entered.
        always_ff @(posedge clk) begin
            if (!rst_n || r_state != ST_LONG || w_fall || r_rc == c_REP_LAST) begin
                r_rc <= '0;
            end else begin
                r_rc <= r_rc + 1'b1;
            end
        end

        assign w_repeat = (r_state == ST_LONG) && !w_fall && (r_rc == c_REP_LAST);
`else
        assign w_repeat = 1'b0;
`endif

        // lock drops pulses outright; state and counters keep running.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_press   <= (w_rise || w_repeat) && !lock;
                r_release <= w_fall && !lock;
                r_long    <= w_long && !lock;
            end
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
        assign btn_long[i]    = r_long;
    end

endmodule

`default_nettype wire

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for the three FPGA push-buttons (prev / pause / next).
- Synchronises the raw pad inputs, debounces them, and emits a clean level plus single-cycle press, release and long-press pulses per button.
- Sits directly upstream of the button control logic, which consumes these pulses to step song number and toggle pause.

Parameters:
N_BTN, 3, number of independent buttons
DB_CYCLES, 2000000, consecutive stable cycles required to accept a level change (20 ms at 100 MHz); must be >= 2
LONG_CYCLES, 100000000, cycles a debounced press must be held before btn_long pulses (1 s)
REPEAT_CYCLES, 20000000, auto-repeat interval for HOLD_REPEAT_EN (200 ms)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
button_raw  in  N_BTN  raw asynchronous button pads, 1 = pressed
lock  in  1  when 1, suppresses btn_press / btn_long / btn_release pulses; levels still tracked
btn_level  out  N_BTN  debounced level
btn_press  out  N_BTN  one-cycle pulse on accepted rising level (and repeats, see option)
btn_release  out  N_BTN  one-cycle pulse on accepted falling level
btn_long  out  N_BTN  one-cycle pulse once per press after LONG_CYCLES held

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - sync flops, btn_level, all pulse outputs, all counters -> 0.
  - Reset has priority over everything and applies mid-debounce or mid-hold: any in-progress count is discarded.
- Synchroniser: 2-flop per bit; s[i] = button_raw[i] delayed 2 cycles.
- Debounce, per button, independent:
  - The stable counter dbc[i] (width clog2(DB_CYCLES)) clears in any cycle where s[i] == btn_level[i].
  - Otherwise dbc[i] increments.
  - When dbc[i] == DB_CYCLES-1 and s[i] != btn_level[i]: btn_level[i] <= s[i] and dbc[i] <= 0.
  - A single glitch cycle resets the count, so the change needs DB_CYCLES consecutive differing cycles.
  - Latency from raw edge (first sampling edge) to btn_level change = DB_CYCLES + 2 cycles.
  - Bounce shorter than DB_CYCLES -> no level change, no pulse.
- Pulses are registered and coincide with the cycle btn_level changes:
  - rise -> btn_press[i] = 1 for exactly one cycle.
  - fall -> btn_release[i] = 1 for exactly one cycle.
  - lock = 1 in the cycle the pulse would fire -> pulse dropped, not deferred.
- Per-button FSM:
  - IDLE: level 0.
  - Level rise -> HELD; hold counter hc[i] <= 0.
  - HELD: hc[i] increments each cycle, saturating at LONG_CYCLES (no wrap).
  - When hc[i] reaches LONG_CYCLES-1: btn_long[i] pulses, state -> LONG.
  - LONG: no further btn_long until the next press.
  - Level fall in HELD or LONG -> IDLE; hc cleared.
- Multiple buttons may change in the same cycle; each output bit is driven only by its own button; no priority between buttons.
- Button held through reset release is treated as a fresh press: btn_press fires DB_CYCLES + 2 cycles after rst_n rises.

Optional Feature:
Macro HOLD_REPEAT_EN.
- Defined:
  - In LONG, a repeat counter counts REPEAT_CYCLES.
  - btn_press[i] re-pulses every REPEAT_CYCLES cycles, first one REPEAT_CYCLES after btn_long, until release.
  - lock suppresses individual repeats; counting continues.
  - Repeat counter clears on release or reset.
- Undefined: no repeat counter logic; btn_press fires only on the debounced rise.

Test Plan (DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=6):
- Reset, raw=000 steady 10 cycles -> all outputs 0, btn_level=000.
- button_raw[1] 0->1 held -> btn_level[1]=1 and btn_press[1] one-cycle pulse exactly 6 cycles after the first sampling edge; other bits 0.
- Bounce on button_raw[0]: pattern 1,1,1,0,1,1,1,0 repeating -> btn_level[0] stays 0, no pulses; then steady 1 -> press after 6 cycles.
- Hold button 2 -> btn_long[2] pulse 20 cycles after btn_press[2], only once.
  - With HOLD_REPEAT_EN: additional btn_press[2] pulses at +6, +12, ... after btn_long.
  - Without HOLD_REPEAT_EN: none.
  - Release -> btn_release[2] pulse 6 cycles after raw falls.
- lock=1 during a press acceptance -> btn_level[0] goes 1, btn_press[0] stays 0. Assert rst_n=0 mid-hold (hc=10) -> next cycle all outputs 0; raw still 1 -> press 6 cycles after rst_n=1.
- buttons 0 and 2 rise same cycle -> btn_press=101 in the same cycle.
